mac_arbiter: RTL

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arb_pkg.sv | 19 +
 rtl/mac_unit.sv | 23 ++
 rtl/mac_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mac_arb_pkg.sv
// Shared defaults, widths and FSM encoding for the
// round-robin multiply-add arbiter.
package mac_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 8;
   localparam int ID_W        = $clog2(NUM_REQ_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int id_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational A*B+C at full precision, split into a
// truncated result and an overflow flag.
module mac_unit
   import mac_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] sum,
   output logic              ovf
);

   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W:0]   full;

   assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   assign full = {1'b0, prod} + {{(DATA_W+1){1'b0}}, c};
   assign sum  = full[DATA_W-1:0];
   assign ovf  = |full[2*DATA_W:DATA_W];

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one multiply-add datapath,
// one operation in flight, result held until accepted.
module mac_arbiter
   import mac_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ID_BITS = id_bits(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] a_in,
   input  logic [NUM_REQ*DATA_W-1:0] b_in,
   input  logic [NUM_REQ*DATA_W-1:0] c_in,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [DATA_W-1:0]         res_data,
   output logic                      res_ovf,
   output logic [ID_BITS-1:0]        res_id,
   output logic                      busy
);

   state_t state, state_n;

   logic [ID_BITS-1:0] ptr, ptr_n;
   logic [ID_BITS-1:0] op_id, op_id_n;
   logic [DATA_W-1:0]  op_a, op_a_n;
   logic [DATA_W-1:0]  op_b, op_b_n;
   logic [DATA_W-1:0]  op_c, op_c_n;

   logic [NUM_REQ-1:0] gnt_n;
   logic               valid_n;
   logic [DATA_W-1:0]  data_n;
   logic               ovf_n;
   logic [ID_BITS-1:0] id_n;

   logic [DATA_W-1:0]  a_arr [NUM_REQ];
   logic [DATA_W-1:0]  b_arr [NUM_REQ];
   logic [DATA_W-1:0]  c_arr [NUM_REQ];

   logic [ID_BITS-1:0] win;
   logic               hit;
   int                 idx;

   logic [DATA_W-1:0]  mac_sum;
   logic               mac_ovf;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign a_arr[g] = a_in[g*DATA_W +: DATA_W];
      assign b_arr[g] = b_in[g*DATA_W +: DATA_W];
      assign c_arr[g] = c_in[g*DATA_W +: DATA_W];
   end

   // Scan upward from ptr with wrap; first set bit wins.
   always_comb begin
      win = '0;
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!hit && req[idx]) begin
            hit = 1'b1;
            win = ID_BITS'(idx);
         end
      end
   end

   mac_unit #(
      .DATA_W (DATA_W)
   ) u_mac (
      .a   (op_a),
      .b   (op_b),
      .c   (op_c),
      .sum (mac_sum),
      .ovf (mac_ovf)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      op_id_n = op_id;
      op_a_n  = op_a;
      op_b_n  = op_b;
      op_c_n  = op_c;
      gnt_n   = '0;
      valid_n = res_valid;
      data_n  = res_data;
      ovf_n   = res_ovf;
      id_n    = res_id;
      unique case (state)
         IDLE: begin
            if (hit) begin
               op_id_n = win;
               op_a_n  = a_arr[win];
               op_b_n  = b_arr[win];
               op_c_n  = c_arr[win];
               gnt_n   = NUM_REQ'(1) << win;
               ptr_n   = (int'(win) == NUM_REQ - 1)
                         ? '0 : win + 1'b1;
               state_n = CALC;
            end
         end
         CALC: begin
            data_n  = mac_sum;
            ovf_n   = mac_ovf;
            id_n    = op_id;
            valid_n = 1'b1;
            state_n = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         op_id     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         gnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_ovf   <= 1'b0;
         res_id    <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         op_id     <= op_id_n;
         op_a      <= op_a_n;
         op_b      <= op_b_n;
         op_c      <= op_c_n;
         gnt       <= gnt_n;
         res_valid <= valid_n;
         res_data  <= data_n;
         res_ovf   <= ovf_n;
         res_id    <= id_n;
      end
   end

   assign busy = (state != IDLE);

endmodule
